ring_phase_monitor: RTL

- Sits directly downstream of the 8-bit one-hot ring counter and samples its count bus every enabled cycle.
- Encodes the one-hot value to a binary phase index and counts completed revolutions.
- Checks that each sample is exactly one-hot and that the ring advances one position per sample, raising pulsed and sticky error flags when it does not.
- Ring order is rotate-left: 8'h80 -> 8'h01 -> 8'h02 -> ... -> 8'h80.

---
 rtl/ring_pkg.sv | 17 +
 rtl/ring_onehot_enc.sv | 27 ++
 rtl/ring_phase_monitor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and helpers for the ring phase monitor
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } ring_state_e;

  localparam int RING_W = 8;

  // The upstream ring counter comes out of reset holding only its top bit.
  function automatic logic [63:0] ring_init_val(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// rtl/ring_onehot_enc.sv - one-hot to binary index encoder with one-hot check
module ring_onehot_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             is_onehot_o
);

  logic [IDX_W-1:0] idx_acc;
  logic             onehot;

  assign onehot = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);

  always_comb begin
    idx_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) idx_acc = idx_acc | i[IDX_W-1:0];
    end
  end

  // Index is forced to zero for illegal vectors so it never carries garbage.
  assign idx_o       = onehot ? idx_acc : '0;
  assign is_onehot_o = onehot;

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - one-hot ring phase tracker with revolution and error counting
// RING_PHASE_MONITOR_HOLD_EN: treat a repeated phase in TRACK as a legal upstream stall.
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH = RING_W,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int REV_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_vld,
  output logic [IDX_W-1:0] phase,
  output logic             phase_vld,
  output logic             wrap,
  output logic [REV_W-1:0] rev_cnt,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [WIDTH-1:0] INIT_VAL  = WIDTH'(ring_init_val(WIDTH));
  localparam logic [IDX_W-1:0] PHASE_MAX = IDX_W'(WIDTH - 1);

  ring_state_e      state_q, state_d;
  logic [IDX_W-1:0] phase_q, phase_d;
  logic             phase_vld_q, phase_vld_d;
  logic             wrap_q, wrap_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_seq_q, err_seq_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_onehot;
  logic [IDX_W-1:0] phase_inc;
  logic             err_any;

  ring_onehot_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i       (ring_in),
    .idx_o       (enc_idx),
    .is_onehot_o (enc_onehot)
  );

  // WIDTH is a power of two, so the natural IDX_W rollover is the ring's modulo.
  assign phase_inc = phase_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    phase_vld_d  = phase_vld_q;
    rev_cnt_d    = rev_cnt_q;
    wrap_d       = 1'b0;
    err_onehot_d = 1'b0;
    err_seq_d    = 1'b0;
    if (ring_vld) begin
      case (state_q)
        IDLE: begin
          if (enc_onehot) begin
            phase_d     = enc_idx;
            phase_vld_d = 1'b1;
            state_d     = TRACK;
          end else begin
            err_onehot_d = 1'b1;
            state_d      = FAULT;
          end
        end
        TRACK: begin
          if (!enc_onehot) begin
            err_onehot_d = 1'b1;
            phase_vld_d  = 1'b0;
            state_d      = FAULT;
          end else if (enc_idx == phase_inc) begin
            phase_d = enc_idx;
            if (phase_q == PHASE_MAX) begin
              wrap_d    = 1'b1;
              rev_cnt_d = rev_cnt_q + REV_W'(1);
            end
`ifdef RING_PHASE_MONITOR_HOLD_EN
          end else if (enc_idx == phase_q) begin
            phase_d = phase_q;
`endif
          end else begin
            err_seq_d = 1'b1;
            phase_d   = enc_idx;
          end
        end
        FAULT: begin
          // Recovery only from the ring's reset value; everything else is ignored quietly.
          if (ring_in == INIT_VAL) begin
            phase_d     = PHASE_MAX;
            phase_vld_d = 1'b1;
            state_d     = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign err_any      = err_onehot_d | err_seq_d;
  assign err_sticky_d = err_sticky_q | err_any;
  assign err_cnt_d    = (err_any && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;

  always_ff @(posedge clk) begin
    if (init) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      phase_vld_q  <= 1'b0;
      wrap_q       <= 1'b0;
      rev_cnt_q    <= '0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      phase_vld_q  <= phase_vld_d;
      wrap_q       <= wrap_d;
      rev_cnt_q    <= rev_cnt_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign phase      = phase_q;
  assign phase_vld  = phase_vld_q;
  assign wrap       = wrap_q;
  assign rev_cnt    = rev_cnt_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule
